network_mac_pipe_sat: RTL and testbench

//  Parametrised pipelined signed multiply-accumulate for the conv/dense datapath.

---
 rtl/network_mac_pkg.sv | 42 ++++
 rtl/network_mac_mul_pipe.sv | 90 +++++++++
 rtl/network_mac_pipe_sat.sv | 119 +++++++++++
 tb/tb_network_mac_pipe_sat.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/network_mac_pkg.sv
// Shared constants and the round/shift/saturate helper for the MAC datapath.
package network_mac_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  // Widest accumulator the helper can handle.
  localparam int SAT_MAX_W = 64;

  typedef struct packed {
    logic                        sat;
    logic signed [SAT_MAX_W-1:0] data;
  } sat_res_t;

  function automatic sat_res_t sat_shift(input logic signed [SAT_MAX_W-1:0] sum,
                                         input int shift,
                                         input int round,
                                         input int out_w);
    logic signed [SAT_MAX_W-1:0] r;
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    sat_res_t                    res;
    r = sum;
    if (round == ROUND_HALF_UP && shift > 0) begin
      r = r + (64'sd1 <<< (shift - 1));
    end
    r  = r >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    res.sat  = 1'b0;
    res.data = r;
    if (r > hi) begin
      res.sat  = 1'b1;
      res.data = hi;
    end else if (r < lo) begin
      res.sat  = 1'b1;
      res.data = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/network_mac_mul_pipe.sv
// Signed multiplier with STAGES register levels (operand register first), carrying valid/last tags.
module network_mac_mul_pipe
  import network_mac_pkg::*;
#(
  parameter int A_W    = 16,
  parameter int B_W    = 14,
  parameter int STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic                       valid_i,
  input  logic                       last_i,
  input  logic signed [A_W-1:0]      a_i,
  input  logic signed [B_W-1:0]      b_i,
  output logic                       valid_o,
  output logic                       last_o,
  output logic signed [A_W+B_W-1:0]  prod_o
);

  localparam int P_W = A_W + B_W;

  logic signed [A_W-1:0] a_q;
  logic signed [B_W-1:0] b_q;
  logic                  op_v_q;
  logic                  op_l_q;
  logic signed [P_W-1:0] prod_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_v_q <= 1'b0;
      op_l_q <= 1'b0;
    end else if (en_i) begin
      op_v_q <= valid_i;
      op_l_q <= last_i;
    end
  end

  // Data registers carry no reset so they pack into the DSP A/B/M/P registers.
  always_ff @(posedge clk) begin
    if (en_i) begin
      a_q <= a_i;
      b_q <= b_i;
    end
  end

  assign prod_w = P_W'(a_q) * P_W'(b_q);

  generate
    if (STAGES == 1) begin : g_comb
      assign prod_o  = prod_w;
      assign valid_o = op_v_q;
      assign last_o  = op_l_q;
    end else begin : g_reg
      logic signed [P_W-1:0] p_q [STAGES-1];
      logic                  v_q [STAGES-1];
      logic                  l_q [STAGES-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < STAGES - 1; i++) begin
            v_q[i] <= 1'b0;
            l_q[i] <= 1'b0;
          end
        end else if (en_i) begin
          v_q[0] <= op_v_q;
          l_q[0] <= op_l_q;
          for (int i = 1; i < STAGES - 1; i++) begin
            v_q[i] <= v_q[i-1];
            l_q[i] <= l_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (en_i) begin
          p_q[0] <= prod_w;
          for (int i = 1; i < STAGES - 1; i++) begin
            p_q[i] <= p_q[i-1];
          end
        end
      end

      assign prod_o  = p_q[STAGES-2];
      assign valid_o = v_q[STAGES-2];
      assign last_o  = l_q[STAGES-2];
    end
  endgenerate

endmodule

// File: rtl/network_mac_pipe_sat.sv
// Pipelined signed MAC: per-frame accumulate, round/shift/saturate, valid/ready on both sides.
module network_mac_pipe_sat
  import network_mac_pkg::*;
#(
  parameter int A_W        = 16,
  parameter int B_W        = 14,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 13,
  parameter int ACC_GUARD  = 8,
  parameter int MUL_STAGES = 2,
  parameter int ROUND      = 1
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [A_W-1:0]   in_a,
  input  logic signed [B_W-1:0]   in_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);

  localparam int P_W   = A_W + B_W;
  localparam int ACC_W = A_W + B_W + ACC_GUARD;

  logic                    advance;
  logic                    mul_v;
  logic                    mul_l;
  logic signed [P_W-1:0]   mul_prod;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    first_q, first_d;
  logic                    acc_v_q, acc_v_d;
  logic                    acc_l_q, acc_l_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  sat_res_t                sat_res;
  logic                    sat_unused;

  // A full output register with no taker freezes the whole pipe.
  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = advance;

  network_mac_mul_pipe #(
    .A_W    (A_W),
    .B_W    (B_W),
    .STAGES (MUL_STAGES)
  ) u_mul (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .en_i    (advance),
    .valid_i (in_valid),
    .last_i  (in_last),
    .a_i     (in_a),
    .b_i     (in_b),
    .valid_o (mul_v),
    .last_o  (mul_l),
    .prod_o  (mul_prod)
  );

  assign sat_res    = sat_shift(SAT_MAX_W'(acc_q), FRAC_SHIFT, ROUND, OUT_W);
  assign sat_unused = ^sat_res.data[SAT_MAX_W-1:OUT_W];

  always_comb begin
    acc_d       = acc_q;
    first_d     = first_q;
    acc_v_d     = acc_v_q;
    acc_l_d     = acc_l_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (advance) begin
      acc_v_d = mul_v;
      acc_l_d = mul_l;
      if (mul_v) begin
        acc_d   = (first_q ? '0 : acc_q) + ACC_W'(mul_prod);
        first_d = mul_l;
      end
      // acc_q already holds the post-add sum of the beat tagged in acc_v_q/acc_l_q.
      if (acc_v_q && acc_l_q) begin
        out_valid_d = 1'b1;
        out_data_d  = sat_res.data[OUT_W-1:0];
        out_sat_d   = sat_res.sat;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      acc_v_q     <= 1'b0;
      acc_l_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      first_q     <= first_d;
      acc_v_q     <= acc_v_d;
      acc_l_q     <= acc_l_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_network_mac_pipe_sat.sv
// Scoreboard bench for network_mac_pipe_sat: a round-half-up and a truncating instance side by side.
module tb_network_mac_pipe_sat;

  localparam int A_W   = 16;
  // One extra weight bit so the Q13 weight 1.0 (8192) is representable.
  localparam int B_W   = 15;
  localparam int OUT_W = 16;

  logic                    ap_clk = 1'b0;
  logic                    ap_rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready, in_ready_t;
  logic signed [A_W-1:0]   in_a = '0;
  logic signed [B_W-1:0]   in_b = '0;
  logic                    in_last = 1'b0;
  logic                    out_valid, out_valid_t;
  logic                    out_ready = 1'b1;
  logic signed [OUT_W-1:0] out_data, out_data_t;
  logic                    out_sat, out_sat_t;

  int total = 0;
  int bad   = 0;

  logic [OUT_W:0] exp_q[$];
  logic [OUT_W:0] obs_q[$];
  logic [OUT_W:0] exp0_q[$];
  logic [OUT_W:0] obs0_q[$];

  always #5 ap_clk = ~ap_clk;

  network_mac_pipe_sat #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .ROUND(1)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  network_mac_pipe_sat #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .ROUND(0)) dut_trunc (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready_t),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid_t),
    .out_ready(out_ready), .out_data(out_data_t), .out_sat(out_sat_t)
  );

  // Record each output handshake that completes at the coming rising edge.
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      if (out_valid && out_ready) obs_q.push_back({out_sat, out_data});
      if (out_valid_t && out_ready) obs0_q.push_back({out_sat_t, out_data_t});
    end
  end

  task automatic send_beat(input int a, input int b, input bit last);
    bit accepted = 1'b0;
    in_valid = 1'b1;
    in_a     = A_W'(a);
    in_b     = B_W'(b);
    in_last  = last;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge ap_clk);
      if (in_ready) accepted = 1'b1;
      @(posedge ap_clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      bad++;
      $display("FAIL send_timeout: beat a=%0d not accepted, in_ready=%0b required 1", a, in_ready);
    end
  endtask

  task automatic wait_obs(input int n, input int n0, output bit ok);
    for (int i = 0; i < 300 && (obs_q.size() < n || obs0_q.size() < n0); i++) @(negedge ap_clk);
    ok = (obs_q.size() >= n) && (obs0_q.size() >= n0);
  endtask

  task automatic test_reset;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    total++; if (out_data !== 16'sd0) begin bad++; $display("FAIL reset_out_data: got %0d required 0", out_data); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL reset_out_sat: got %0b required 0", out_sat); end
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    $display("[reset] released");
  endtask

  task automatic test_one_beat;
    bit ok;
    logic [OUT_W:0] e, o;
    @(posedge ap_clk); #1;
    send_beat(256, 8192, 1'b1);
    exp_q.push_back({1'b0, 16'sd256});
    for (int n = 0; n < 4; n++) begin
      @(negedge ap_clk);
      if (n == 2) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early: out_valid=%0b after edge k+2, required 0", out_valid); end
      end
      if (n == 3) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL latency_k3: out_valid=%0b after edge k+3, required 1", out_valid); end
      end
    end
    wait_obs(exp_q.size(), 0, ok);
    total++; if (!ok) begin bad++; $display("FAIL one_beat_timeout: got %0d outputs required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("[one_beat] data=%0d sat=%0b", $signed(o[OUT_W-1:0]), o[OUT_W]);
      total++; if (o !== e) begin bad++; $display("FAIL one_beat: got data=%0d sat=%0b required data=%0d sat=%0b", $signed(o[OUT_W-1:0]), o[OUT_W], $signed(e[OUT_W-1:0]), e[OUT_W]); end
    end
    obs0_q.delete();
  endtask

  task automatic test_frame;
    bit ok;
    logic [OUT_W:0] e, o;
    @(posedge ap_clk); #1;
    send_beat(100, 8192, 1'b0);
    send_beat(-50, 8192, 1'b0);
    send_beat(10, 4096, 1'b1);
    exp_q.push_back({1'b0, 16'sd55});
    send_beat(7, 8192, 1'b1);
    exp_q.push_back({1'b0, 16'sd7});
    wait_obs(exp_q.size(), 0, ok);
    total++; if (!ok) begin bad++; $display("FAIL frame_timeout: got %0d outputs required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("[frame] data=%0d sat=%0b", $signed(o[OUT_W-1:0]), o[OUT_W]);
      total++; if (o !== e) begin bad++; $display("FAIL frame: got data=%0d sat=%0b required data=%0d sat=%0b", $signed(o[OUT_W-1:0]), o[OUT_W], $signed(e[OUT_W-1:0]), e[OUT_W]); end
    end
    obs0_q.delete();
  endtask

  task automatic test_saturation;
    bit ok;
    logic [OUT_W:0] e, o;
    @(posedge ap_clk); #1;
    for (int i = 0; i < 4; i++) send_beat(32767, 8191, i == 3);
    exp_q.push_back({1'b1, 16'sh7FFF});
    for (int i = 0; i < 2; i++) send_beat(-32768, 8191, i == 1);
    exp_q.push_back({1'b1, 16'sh8000});
    wait_obs(exp_q.size(), 0, ok);
    total++; if (!ok) begin bad++; $display("FAIL sat_timeout: got %0d outputs required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("[saturation] data=%0d sat=%0b", $signed(o[OUT_W-1:0]), o[OUT_W]);
      total++; if (o !== e) begin bad++; $display("FAIL saturation: got data=%0d sat=%0b required data=%0d sat=%0b", $signed(o[OUT_W-1:0]), o[OUT_W], $signed(e[OUT_W-1:0]), e[OUT_W]); end
    end
    obs0_q.delete();
  endtask

  task automatic test_rounding;
    bit ok;
    logic [OUT_W:0] e, o;
    @(posedge ap_clk); #1;
    send_beat(3, 4096, 1'b1);
    exp_q.push_back({1'b0, 16'sd2});
    exp0_q.push_back({1'b0, 16'sd1});
    send_beat(-3, 4096, 1'b1);
    exp_q.push_back({1'b0, 16'shFFFF});
    exp0_q.push_back({1'b0, 16'shFFFE});
    wait_obs(exp_q.size(), exp0_q.size(), ok);
    total++; if (!ok) begin bad++; $display("FAIL round_timeout: got %0d/%0d outputs required %0d/%0d", obs_q.size(), obs0_q.size(), exp_q.size(), exp0_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("[round_half_up] data=%0d sat=%0b", $signed(o[OUT_W-1:0]), o[OUT_W]);
      total++; if (o !== e) begin bad++; $display("FAIL round_half_up: got data=%0d sat=%0b required data=%0d sat=%0b", $signed(o[OUT_W-1:0]), o[OUT_W], $signed(e[OUT_W-1:0]), e[OUT_W]); end
    end
    while (exp0_q.size() > 0 && obs0_q.size() > 0) begin
      e = exp0_q.pop_front(); o = obs0_q.pop_front();
      $display("[round_trunc] data=%0d sat=%0b", $signed(o[OUT_W-1:0]), o[OUT_W]);
      total++; if (o !== e) begin bad++; $display("FAIL round_trunc: got data=%0d sat=%0b required data=%0d sat=%0b", $signed(o[OUT_W-1:0]), o[OUT_W], $signed(e[OUT_W-1:0]), e[OUT_W]); end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [OUT_W:0] e, o;
    @(posedge ap_clk); #1;
    fork
      begin
        for (int a = 1; a <= 8; a++) begin
          send_beat(a, 8192, 1'b1);
          exp_q.push_back({1'b0, OUT_W'(a)});
        end
      end
      begin
        // Frame 1 leaves at edge 5, so frame 2's result sits in the output register during the stall.
        repeat (5) @(posedge ap_clk);
        #1 out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge ap_clk);
          total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: cycle %0d got %0b required 0", s, in_ready); end
          total++; if (out_valid !== 1'b1 || out_data !== 16'sd2) begin bad++; $display("FAIL stall_hold: cycle %0d got valid=%0b data=%0d required valid=1 data=2", s, out_valid, out_data); end
        end
        @(posedge ap_clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_obs(exp_q.size(), 0, ok);
    total++; if (!ok || obs_q.size() != 8) begin bad++; $display("FAIL b2b_count: got %0d outputs required 8", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("[back_to_back] data=%0d sat=%0b", $signed(o[OUT_W-1:0]), o[OUT_W]);
      total++; if (o !== e) begin bad++; $display("FAIL back_to_back: got data=%0d sat=%0b required data=%0d sat=%0b", $signed(o[OUT_W-1:0]), o[OUT_W], $signed(e[OUT_W-1:0]), e[OUT_W]); end
    end
    obs0_q.delete();
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic [OUT_W:0] e, o;
    @(posedge ap_clk); #1;
    send_beat(5, 8192, 1'b1);
    send_beat(1000, 8192, 1'b0);
    send_beat(1000, 8192, 1'b0);
    out_ready = 1'b0;
    repeat (2) @(negedge ap_clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid: got %0b required 1", out_valid); end
    #1 ap_rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid: got %0b required 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL async_reset_ready: got %0b required 1", in_ready); end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    out_ready = 1'b1;
    obs_q.delete();
    obs0_q.delete();
    @(posedge ap_clk); #1;
    send_beat(7, 8192, 1'b1);
    exp_q.push_back({1'b0, 16'sd7});
    wait_obs(exp_q.size(), 0, ok);
    total++; if (!ok) begin bad++; $display("FAIL reset_mid_timeout: got %0d outputs required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("[reset_mid] data=%0d sat=%0b", $signed(o[OUT_W-1:0]), o[OUT_W]);
      total++; if (o !== e) begin bad++; $display("FAIL reset_mid: got data=%0d sat=%0b required data=%0d sat=%0b", $signed(o[OUT_W-1:0]), o[OUT_W], $signed(e[OUT_W-1:0]), e[OUT_W]); end
    end
  endtask

  initial begin
    test_reset();
    test_one_beat();
    test_frame();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
